// File: rtl/data_mem_be_if.sv
// Request/response bus for the byte-enabled data memory.
// The master side is the load/store unit. The slave side is the memory.
interface data_mem_be_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ack;
    logic        busy;
    logic        err;

    modport master (output req, we, addr, wdata, be, input rdata, ack, busy, err);
    modport slave  (input req, we, addr, wdata, be, output rdata, ack, busy, err);
endinterface

// File: rtl/data_mem_be.sv
// Word-organised data memory with byte enables and a WAIT_CYCLES-deep req/ack handshake.
// Optional DMEM_WRITE_READBACK_EN: a legal store also returns the merged word on rdata.
module data_mem_be #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    data_mem_be_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt;
    logic                we_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [3:0]          be_q;
    logic                err_q;
    logic [31:0]         rdata_q;
    logic [31:0]         mem [2**ADDR_W];

    logic                idle, commit, legal, be_ok;
    logic                cur_we;
    logic [ADDR_W+1:0]   cur_addr;
    logic [31:0]         cur_wdata, merged;
    logic [3:0]          cur_be;
    logic [ADDR_W-1:0]   idx;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

    // With zero wait states, commit happens on the accept edge, so the live bus is used.
    assign idle      = (state == S_IDLE);
    assign cur_we    = idle ? bus.we                 : we_q;
    assign cur_addr  = idle ? bus.addr[ADDR_W+1:0]   : addr_q;
    assign cur_wdata = idle ? bus.wdata              : wdata_q;
    assign cur_be    = idle ? bus.be                 : be_q;
    assign idx       = cur_addr[ADDR_W+1:2];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.req) state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;
            S_WAIT:  if (cnt == 4'd1) state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        be_ok = 1'b0;
        case (cur_be)
            4'b1111: be_ok = (cur_addr[1:0] == 2'd0);
            4'b0001: be_ok = (cur_addr[1:0] == 2'd0);
            4'b0010: be_ok = (cur_addr[1:0] == 2'd1);
            4'b0100: be_ok = (cur_addr[1:0] == 2'd2);
            4'b1000: be_ok = (cur_addr[1:0] == 2'd3);
            default: be_ok = 1'b0;
        endcase
        legal  = !cur_we || be_ok;
        merged = mem[idx];
        for (int k = 0; k < 4; k++)
            if (cur_be[k])
                merged[8*k +: 8] = (cur_be == 4'hF) ? cur_wdata[8*k +: 8] : cur_wdata[7:0];
    end

    assign commit = (state_nxt == S_ACK) && (state != S_ACK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (idle && bus.req) begin
                we_q    <= bus.we;
                addr_q  <= bus.addr[ADDR_W+1:0];
                wdata_q <= bus.wdata;
                be_q    <= bus.be;
                cnt     <= 4'(WAIT_CYCLES);
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                err_q <= !legal;
                if (!cur_we)
                    rdata_q <= mem[idx];
`ifdef DMEM_WRITE_READBACK_EN
                else if (legal)
                    rdata_q <= merged;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && commit && cur_we && legal)
            mem[idx] <= merged;
    end

    assign bus.ack   = (state == S_ACK);
    assign bus.busy  = (state != S_IDLE);
    assign bus.err   = (state == S_ACK) && err_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_data_mem_be.sv
// Directed test of data_mem_be: one instance with WAIT_CYCLES=2 and one with WAIT_CYCLES=0.
// A shared driver is steered to one instance at a time by dsel.
module tb_data_mem_be;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    int          dsel = 0;
    int          n_chk = 0;
    int          n_fail = 0;

`ifdef DMEM_WRITE_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    always #5 clk = ~clk;

    data_mem_be_if b0();
    data_mem_be_if b1();

    assign b0.req = req && (dsel == 0);
    assign b0.we = we;
    assign b0.addr = addr;
    assign b0.wdata = wdata;
    assign b0.be = be;
    assign b1.req = req && (dsel == 1);
    assign b1.we = we;
    assign b1.addr = addr;
    assign b1.wdata = wdata;
    assign b1.be = be;

    data_mem_be #(.ADDR_W(8), .WAIT_CYCLES(2)) u0 (.clk(clk), .reset(rst), .bus(b0));
    data_mem_be #(.ADDR_W(8), .WAIT_CYCLES(0)) u1 (.clk(clk), .reset(rst), .bus(b1));

    logic        m_ack, m_busy, m_err;
    logic [31:0] m_rdata;
    always_comb begin
        m_ack   = (dsel == 0) ? b0.ack   : b1.ack;
        m_busy  = (dsel == 0) ? b0.busy  : b1.busy;
        m_err   = (dsel == 0) ? b0.err   : b1.err;
        m_rdata = (dsel == 0) ? b0.rdata : b1.rdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_idle();
        @(negedge clk);
        for (int i = 0; i < 40 && m_busy; i++) @(negedge clk);
    endtask

    task automatic acc(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                       output logic [31:0] rd, output logic e, output int lat, output int bz);
        wait_idle();
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 1; bz = 0;
        while (!m_ack && lat < 40) begin
            bz += int'(m_busy);
            @(posedge clk); #1;
            lat++;
        end
        bz += int'(m_busy);
        rd = m_rdata;
        e  = m_err;
    endtask

    task automatic st(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                      input logic exp_err, input logic [31:0] exp_rd);
        logic [31:0] rd; logic e; int lat, bz;
        acc(1'b1, a, d, b, rd, e, lat, bz);
        check({tag, "_lat"}, lat, (dsel == 0) ? 3 : 1);
        check({tag, "_err"}, e, exp_err);
        check({tag, "_rd"}, rd, exp_rd);
    endtask

    task automatic ld(input string tag, input logic [31:0] a, input logic [3:0] b, input logic [31:0] exp);
        logic [31:0] rd; logic e; int lat, bz;
        acc(1'b0, a, 32'hFFFF_FFFF, b, rd, e, lat, bz);
        check({tag, "_lat"}, lat, (dsel == 0) ? 3 : 1);
        check({tag, "_busy"}, bz, (dsel == 0) ? 3 : 1);
        check({tag, "_err"}, e, 1'b0);
        check({tag, "_rd"}, rd, exp);
    endtask

    initial begin
        int acks;
        logic [3:0] pat, bpat;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", m_ack, 1'b0);
        check("rst_busy", m_busy, 1'b0);
        check("rst_err", m_err, 1'b0);
        check("rst_rdata", m_rdata, 32'h0);
        @(negedge clk); rst = 1'b0;

        st("sw10", 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, RB ? 32'hDEADBEEF : 32'h0);
        @(posedge clk); #1;
        check("sw10_busy_after", m_busy, 1'b0);
        ld("lw10a", 32'h10, 4'b1111, 32'hDEADBEEF);
        st("sb12", 32'h12, 32'h000000A5, 4'b0100, 1'b0, RB ? 32'hDEA5BEEF : 32'hDEADBEEF);
        ld("lw10b", 32'h10, 4'b1111, 32'hDEA5BEEF);
        st("sw11_mis", 32'h11, 32'h01010101, 4'b1111, 1'b1, 32'hDEA5BEEF);
        ld("lw10c", 32'h10, 4'b1111, 32'hDEA5BEEF);
        st("sb13_lane", 32'h13, 32'h00000099, 4'b0001, 1'b1, 32'hDEA5BEEF);
        st("s10_be3", 32'h10, 32'h00005555, 4'b0011, 1'b1, 32'hDEA5BEEF);
        ld("lw10d", 32'h10, 4'b1111, 32'hDEA5BEEF);
        st("sb10_rb", 32'h10, 32'h00000077, 4'b0001, 1'b0, RB ? 32'hDEA5BE77 : 32'hDEA5BEEF);
        ld("lw13_anybe", 32'h13, 4'b0110, 32'hDEA5BE77);
        ld("lw410_wrap", 32'h410, 4'b1111, 32'hDEA5BE77);
        st("sw50", 32'h50, 32'h0, 4'b1111, 1'b0, RB ? 32'h0 : 32'hDEA5BE77);
        st("sb53", 32'h53, 32'h0000007E, 4'b1000, 1'b0, RB ? 32'h7E000000 : 32'hDEA5BE77);
        ld("lw50", 32'h50, 4'b1111, 32'h7E000000);

        // A request raised while the memory is in WAIT must be dropped.
        st("sw20", 32'h20, 32'h12345678, 4'b1111, 1'b0, RB ? 32'h12345678 : 32'h7E000000);
        st("sw30", 32'h30, 32'hAABBCCDD, 4'b1111, 1'b0, RB ? 32'hAABBCCDD : 32'h7E000000);
        wait_idle();
        req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'h55; be = 4'b1111;
        @(negedge clk);
        addr = 32'h20; wdata = 32'hBAD0BAD0;
        @(negedge clk);
        req = 1'b0;
        acks = 0;
        repeat (8) begin @(posedge clk); #1; acks += int'(m_ack); end
        check("ign_acks", acks, 1);
        ld("lw20", 32'h20, 4'b1111, 32'h12345678);
        ld("lw40", 32'h40, 4'b1111, 32'h00000055);

        // Reset during WAIT drops the uncommitted store.
        wait_idle();
        req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'h11223344; be = 4'b1111;
        @(negedge clk);
        req = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", m_busy, 1'b0);
        check("midrst_ack", m_ack, 1'b0);
        check("midrst_rdata", m_rdata, 32'h0);
        @(negedge clk); rst = 1'b0;
        acks = 0;
        repeat (5) begin @(posedge clk); #1; acks += int'(m_ack); end
        check("midrst_noack", acks, 0);
        ld("lw30", 32'h30, 4'b1111, 32'hAABBCCDD);

        // Reset and req in the same cycle: nothing accepted.
        wait_idle();
        rst = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h30;
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        @(posedge clk); #1;
        check("rstreq_busy", m_busy, 1'b0);
        check("rstreq_ack", m_ack, 1'b0);

        // Zero wait states: ack directly after the accept edge, back-to-back on held req.
        wait_idle();
        dsel = 1;
        st("z_sw30", 32'h30, 32'h01020304, 4'b1111, 1'b0, RB ? 32'h01020304 : 32'h0);
        ld("z_lw30", 32'h30, 4'b1111, 32'h01020304);
        wait_idle();
        req = 1'b1; we = 1'b0; addr = 32'h30; be = 4'b1111;
        pat = '0; bpat = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            pat = {pat[2:0], m_ack};
            bpat = {bpat[2:0], m_busy};
        end
        @(negedge clk); req = 1'b0;
        check("z_b2b_ack", pat, 4'b1010);
        check("z_b2b_busy", bpat, 4'b1010);
        check("z_b2b_rd", m_rdata, 32'h01020304);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule

// File: doc/data_mem_be.md
Name: data_mem_be

Overview:
- Byte-enabled, word-organised data memory that consumes the store datapath's outputs: new data (wdata, byte payload in bits [7:0] for byte stores) and byte enables (be).
- Serves loads and stores through a req/ack handshake with a configurable number of wait states, modelling a multi-cycle data memory.
- Sits between the store-lane logic / ALU address path and the load-extension / writeback stage.

Parameters:
ADDR_W, 8, word-address bits; depth = 2**ADDR_W 32-bit words
WAIT_CYCLES, 2, extra cycles between request accept and ack (0..15)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req  input  1  access request; sampled only in IDLE
we  input  1  1 = store, 0 = load
addr  input  32  byte address; word index = addr[ADDR_W+1:2]
wdata  input  32  store data; full word for sw, byte in [7:0] for sb
be  input  4  byte enables: 1111 word, one-hot single byte lane
rdata  output  32  read word; valid when ack=1 on a load
ack  output  1  one-cycle completion pulse
busy  output  1  high from accept until the ack cycle inclusive
err  output  1  pulses with ack on an illegal access

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values: rdata=0, ack=0, busy=0, err=0, FSM=IDLE, wait counter=0. Memory array is not cleared.
- FSM states: IDLE, WAIT, ACK.
- IDLE with req=1 (accept):
  - latch we, addr, wdata, be;
  - busy=1 next cycle;
  - go to WAIT if WAIT_CYCLES>0 and load counter with WAIT_CYCLES, else go to ACK.
- IDLE with req=0: stay.
- WAIT: decrement counter each cycle; when counter reaches 1, go to ACK.
- Commit at the transition into ACK, using the latched values:
  - Load: rdata <= mem[idx].
  - Store, be=1111: mem[idx] <= wdata.
  - Store, be one-hot lane k: mem[idx][8k+7:8k] <= wdata[7:0]; other lanes unchanged.
- ACK: ack=1 for exactly one cycle, busy=1, then return to IDLE with busy=0.
- Latency: ack is asserted WAIT_CYCLES+1 cycles after the accept edge. Back-to-back: req held high is accepted again in the cycle after ACK.
- req while busy (WAIT/ACK): ignored, not queued.
- Illegal access, flagged with err=1 in the ACK cycle; no memory write, rdata unchanged:
  - be=1111 with addr[1:0]!=00 (misaligned word);
  - be not in {0001, 0010, 0100, 1000, 1111};
  - be lane not matching addr[1:0] on a byte store (e.g. be=0100 with addr[1:0]=01).
- Loads ignore be; alignment is not checked on loads.
- Stores leave rdata unchanged (base build).
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo the depth.
- Reset mid-operation (in WAIT or ACK): return to IDLE, no ack. A store not yet committed is dropped.
- reset and req asserted in the same cycle: reset wins, nothing accepted.

Optional Feature:
- Macro: DMEM_WRITE_READBACK_EN
- Defined: on a legal store, rdata is updated at commit with the post-write word (merged value), so ack on a store also returns the resulting word.
- Undefined: stores never modify rdata.
- Timing and err behaviour are identical in both builds.

Test Plan:
- WAIT_CYCLES=2: store addr=0x10, be=1111, wdata=0xDEADBEEF; then load addr=0x10 -> ack exactly 3 cycles after each accept; load rdata=0xDEADBEEF; busy high 3 cycles per access.
- After the above: store addr=0x12, be=0100, wdata=0x000000A5; load 0x10 -> rdata=0xDEA5BEEF.
- Store addr=0x11, be=1111 -> err=1 with ack; a subsequent load of 0x10 still returns 0xDEA5BEEF. Store addr=0x13, be=0001 -> err=1, no write.
- req pulsed again during WAIT (second store to 0x20) -> ignored; load 0x20 returns the prior contents; exactly one ack is seen for the first request.
- reset asserted one cycle after accepting a store to 0x30 (0x11223344) -> no ack, busy=0 next cycle; load 0x30 returns the old value. Repeat with WAIT_CYCLES=0 -> ack on the cycle after accept.
- DMEM_WRITE_READBACK_EN defined: store be=0001, wdata=0x77 to 0x10 holding 0xDEA5BEEF -> rdata=0xDEA5BE77 at ack. Undefined: rdata keeps the last load value.
